// File: rtl/control_unit_p_pkg.sv
// Shared types for the ProjectB control unit: FSM state codes, opcodes,
// ALU select values and instruction field positions.
package cu_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_LOAD_A    = 4'd3,
        S_LOAD_B    = 4'd4,
        S_STORE     = 4'd5,
        S_ADD       = 4'd6,
        S_SUB       = 4'd7,
        S_NOOP      = 4'd8,
        S_HALT      = 4'd9,
        S_JUMP      = 4'd10,
        S_BRZ       = 4'd11,
        S_SETTLE    = 4'd12,
        S_STEP_WAIT = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JMP   = 4'd6,
        OP_BRZ   = 4'd7
    } opcode_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Bit positions inside the 16-bit instruction word.
    localparam int FLD_OPC     = 12;  // IR[15:12]
    localparam int FLD_HI      = 8;   // IR[11:8]
    localparam int FLD_MID     = 4;   // IR[7:4]
    localparam int FLD_LO      = 0;   // IR[3:0]
    localparam int FLD_ST_ADDR = 4;   // IR[11:4]
    localparam int FLD_LD_ADDR = 0;   // IR[7:0]
    localparam int NIB_W       = 4;
    localparam int DADDR_W     = 8;

endpackage

// File: rtl/control_unit_p_if.sv
// Bus between the control unit and the ProjectB datapath / instruction ROM.
interface control_unit_p_if #(
    parameter int PC_W = 7
);
    // No valid/ready handshake on this bus: imem_data is the synchronous ROM
    // output for the address sampled on the previous clock edge, alu_zero is
    // combinational from the datapath, and every control output is valid for
    // the whole cycle in which OutState shows the owning state.
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            alu_zero;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_s;
    logic            RF_W_en;
    logic [3:0]      RF_W_addr;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      ALU_s0;
    logic [15:0]     IR_Out;
    logic [PC_W-1:0] PC_Out;
    logic [3:0]      OutState;
    logic [3:0]      NextState;
    logic            halted;

    modport master (
        output imem_addr, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr,
               RF_Rb_addr, ALU_s0, IR_Out, PC_Out, OutState, NextState, halted,
        input  imem_data, alu_zero
    );

    modport slave (
        input  imem_addr, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr,
               RF_Rb_addr, ALU_s0, IR_Out, PC_Out, OutState, NextState, halted,
        output imem_data, alu_zero
    );
endinterface

// File: rtl/control_unit_p_pc.sv
// Program counter: asynchronous active-low reset to RESET_PC,
// priority load > clear > up, wraps modulo 2^PC_W.
module pc_counter_p #(
    parameter int PC_W     = 7,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic            up,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);
    localparam logic [PC_W-1:0] RST_VAL = PC_W'(RESET_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RST_VAL;
        end else if (load) begin
            pc <= load_val;
        end else if (clear) begin
            pc <= RST_VAL;
        end else if (up) begin
            pc <= pc + PC_W'(1);
        end
    end
endmodule

// File: rtl/control_unit_p.sv
// Fetch/decode/execute control unit for ProjectB with external instruction ROM.
// Optional single-step mode (extra 'step' port, STEP_WAIT state): define SINGLE_STEP_EN.
module control_unit_p
    import cu_pkg::*;
#(
    parameter int PC_W     = 7,
    parameter int RESET_PC = 0,
    parameter int DMEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    control_unit_p_if.master bus
);
    localparam int LAT_W = (DMEM_LAT > 1) ? $clog2(DMEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DMEM_LAT - 1);

`ifdef SINGLE_STEP_EN
    localparam state_t DONE_ST = S_STEP_WAIT;
`else
    localparam state_t DONE_ST = S_FETCH;
`endif

    state_t          state, state_nxt;
    logic [15:0]     ir;
    logic [LAT_W-1:0] lat_cnt;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode;
    logic            pc_up, pc_load, pc_clear;

    logic [7:0]      d_addr;
    logic            d_wr, rf_s, rf_w_en, is_halted;
    logic [3:0]      rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0]      alu_s0;

    assign opcode = ir[FLD_OPC +: NIB_W];

    pc_counter_p #(
        .PC_W    (PC_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (reset),
        .load    (pc_load),
        .clear   (pc_clear),
        .up      (pc_up),
        .load_val(ir[PC_W-1:0]),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_INIT;
            ir      <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir <= bus.imem_data;
            end
            // Counts LOAD_A cycles; zero in every other state so each load starts fresh.
            lat_cnt <= (state == S_LOAD_A) ? lat_cnt + LAT_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt  = state;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_en    = 1'b0;
        rf_w_addr  = '0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_PASS;
        is_halted  = 1'b0;
        pc_up      = 1'b0;
        pc_load    = 1'b0;
        pc_clear   = 1'b0;

        case (state)
            S_INIT: state_nxt = S_FETCH;
            S_FETCH: begin
                pc_up     = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    OP_JMP:   state_nxt = S_JUMP;
                    OP_BRZ:   state_nxt = S_BRZ;
                    default:  state_nxt = S_NOOP;
                endcase
            end
            S_LOAD_A: begin
                d_addr    = ir[FLD_LD_ADDR +: DADDR_W];
                rf_w_addr = ir[FLD_HI +: NIB_W];
                rf_s      = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                d_addr    = ir[FLD_LD_ADDR +: DADDR_W];
                rf_w_addr = ir[FLD_HI +: NIB_W];
                rf_s      = 1'b1;
                rf_w_en   = 1'b1;
                state_nxt = DONE_ST;
            end
            S_STORE: begin
                d_addr     = ir[FLD_ST_ADDR +: DADDR_W];
                rf_ra_addr = ir[FLD_LO +: NIB_W];
                d_wr       = 1'b1;
                state_nxt  = DONE_ST;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = ir[FLD_HI +: NIB_W];
                rf_rb_addr = ir[FLD_MID +: NIB_W];
                rf_w_addr  = ir[FLD_LO +: NIB_W];
                rf_w_en    = 1'b1;
                alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                state_nxt  = DONE_ST;
            end
            S_NOOP: state_nxt = DONE_ST;
            S_HALT: is_halted = 1'b1;
            S_JUMP: begin
                pc_load   = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_BRZ: begin
                rf_ra_addr = ir[FLD_HI +: NIB_W];
                alu_s0     = ALU_PASS;
                if (bus.alu_zero) begin
                    pc_load   = 1'b1;
                    state_nxt = S_SETTLE;
                end else begin
                    state_nxt = DONE_ST;
                end
            end
            // ROM samples the freshly loaded PC during this cycle.
            S_SETTLE: state_nxt = DONE_ST;
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step) begin
                    state_nxt = S_FETCH;
                end
            end
`endif
            default: begin
                pc_clear  = 1'b1;
                state_nxt = S_INIT;
            end
        endcase
    end

    assign bus.imem_addr  = pc;
    assign bus.PC_Out     = pc;
    assign bus.IR_Out     = ir;
    assign bus.OutState   = state;
    assign bus.NextState  = state_nxt;
    assign bus.D_addr     = d_addr;
    assign bus.D_wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_W_addr  = rf_w_addr;
    assign bus.RF_Ra_addr = rf_ra_addr;
    assign bus.RF_Rb_addr = rf_rb_addr;
    assign bus.ALU_s0     = alu_s0;
    assign bus.halted     = is_halted;
endmodule

// File: tb/tb_control_unit_p.sv
// Bench for control_unit_p: ISA-level reference model feeds an expected-event
// queue; a negedge monitor pops and compares each observed bus event.
module tb_control_unit_p;
  import cu_pkg::*;

  localparam int PC_W     = 7;
  localparam int RESET_PC = 0;
  localparam int DMEM_LAT = 3;
  localparam int ROM_N    = 1 << PC_W;
`ifdef SINGLE_STEP_EN
  localparam int STEP_X = 1;
  logic step = 1'b1;
`else
  localparam int STEP_X = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_w_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_p_if #(.PC_W(PC_W)) bus ();
  control_unit_p_if #(.PC_W(3)) wbus ();

  control_unit_p #(.PC_W(PC_W), .RESET_PC(RESET_PC), .DMEM_LAT(DMEM_LAT)) dut (
    .clk  (clk),
    .reset(rst_n),
`ifdef SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  control_unit_p #(.PC_W(3), .RESET_PC(0), .DMEM_LAT(1)) u_wrap (
    .clk  (clk),
    .reset(rst_w_n),
`ifdef SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (wbus)
  );

  assign wbus.imem_data = 16'h0000;
  assign wbus.alu_zero  = 1'b0;

  // ---------------- environment: ROM + datapath ----------------
  logic [15:0] rom [ROM_N];
  logic [7:0]  dmem_init [256];
  logic [7:0]  dp_regs [16];
  logic [7:0]  dp_dmem [256];
  logic [7:0]  alu_a, alu_b, alu_res;

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  always_comb begin
    alu_a = dp_regs[bus.RF_Ra_addr];
    alu_b = dp_regs[bus.RF_Rb_addr];
    case (bus.ALU_s0)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      default: alu_res = alu_a;
    endcase
  end
  assign bus.alu_zero = (alu_res == 8'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) dp_regs[i] <= 8'd0;
      for (int i = 0; i < 256; i++) dp_dmem[i] <= dmem_init[i];
    end else begin
      if (bus.RF_W_en) dp_regs[bus.RF_W_addr] <= bus.RF_s ? dp_dmem[bus.D_addr] : alu_res;
      if (bus.D_wr) dp_dmem[bus.D_addr] <= dp_regs[bus.RF_Ra_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int halt_pc;

  function automatic logic [31:0] ev_fetch(input int gap, input int addr);
    return {3'd0, 8'(gap), 8'(addr), 13'd0};
  endfunction
  function automatic logic [31:0] ev_rfw(input logic [3:0] wa, input logic s, input logic [2:0] alu,
                                         input logic [7:0] da, input logic [3:0] ra, input logic [3:0] rb,
                                         input int dwell);
    return {3'd1, wa, s, alu, da, ra, rb, 4'(dwell), 1'b0};
  endfunction
  function automatic logic [31:0] ev_store(input logic [7:0] da, input logic [3:0] ra);
    return {3'd2, da, ra, 17'd0};
  endfunction
  function automatic logic [31:0] ev_halt(input int pc);
    return {3'd3, 8'(pc), 21'd0};
  endfunction
  function automatic logic [31:0] ev_brz(input logic [3:0] ra, input logic [2:0] alu);
    return {3'd4, ra, alu, 22'd0};
  endfunction
  function automatic logic [31:0] ev_settle(input int pc);
    return {3'd5, 8'(pc), 21'd0};
  endfunction

  function automatic string ev_name(input logic [31:0] e);
    case (e[31:29])
      3'd0: return "fetch";
      3'd1: return "rf_write";
      3'd2: return "store";
      3'd3: return "halt";
      3'd4: return "brz";
      3'd5: return "settle";
      default: return "event";
    endcase
  endfunction

  task automatic check(input bit ok, input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, expv);
  endtask

  task automatic observe(input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check(1'b0, {"unexpected_", ev_name(got)}, got, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e === got, ev_name(e), got, e);
    end
  endtask

  function automatic logic [31:0] ctl_bits();
    return {5'd0, bus.D_addr, bus.D_wr, bus.RF_s, bus.RF_W_en, bus.RF_W_addr,
            bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0, bus.halted};
  endfunction

  // ---------------- monitor ----------------
  int   gap_cnt = 0;
  int   dwell_cnt = 0;
  logic halted_q = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      gap_cnt = 0;
      dwell_cnt = 0;
      halted_q = 1'b0;
    end else begin
      if (bus.OutState == S_FETCH) begin
        observe(ev_fetch(gap_cnt, int'(bus.PC_Out)));
        gap_cnt = 1;
      end else begin
        gap_cnt++;
      end
      if (bus.RF_W_en)
        observe(ev_rfw(bus.RF_W_addr, bus.RF_s, bus.ALU_s0, bus.D_addr,
                       bus.RF_Ra_addr, bus.RF_Rb_addr, dwell_cnt));
      if (bus.OutState == S_LOAD_A) dwell_cnt++;
      else dwell_cnt = 0;
      if (bus.D_wr) observe(ev_store(bus.D_addr, bus.RF_Ra_addr));
      if (bus.OutState == S_BRZ) observe(ev_brz(bus.RF_Ra_addr, bus.ALU_s0));
      if (bus.OutState == S_SETTLE) observe(ev_settle(int'(bus.PC_Out)));
      if (bus.halted && !halted_q) observe(ev_halt(int'(bus.PC_Out)));
      halted_q = bus.halted;
    end
  end

  // ---------------- reference model (instruction-level interpreter) ----------------
  task automatic model_run();
    logic [7:0]  r [16];
    logic [7:0]  m [256];
    logic [15:0] w;
    int pc, gap, lat, tgt, steps;
    bit done;
    for (int i = 0; i < 16; i++) r[i] = 8'd0;
    for (int i = 0; i < 256; i++) m[i] = dmem_init[i];
    pc = RESET_PC; gap = 1; done = 1'b0; steps = 0;
    while (!done && steps < 1000) begin
      steps++;
      w = rom[pc];
      exp_q.push_back(ev_fetch(gap, pc));
      pc = (pc + 1) % ROM_N;
      tgt = int'(w) % ROM_N;
      lat = 1;
      case (w[15:12])
        4'd1: begin
          exp_q.push_back(ev_store(w[11:4], w[3:0]));
          m[w[11:4]] = r[w[3:0]];
        end
        4'd2: begin
          exp_q.push_back(ev_rfw(w[11:8], 1'b1, 3'd0, w[7:0], 4'd0, 4'd0, DMEM_LAT));
          r[w[11:8]] = m[w[7:0]];
          lat = DMEM_LAT + 1;
        end
        4'd3: begin
          exp_q.push_back(ev_rfw(w[3:0], 1'b0, 3'd1, 8'd0, w[11:8], w[7:4], 0));
          r[w[3:0]] = r[w[11:8]] + r[w[7:4]];
        end
        4'd4: begin
          exp_q.push_back(ev_rfw(w[3:0], 1'b0, 3'd2, 8'd0, w[11:8], w[7:4], 0));
          r[w[3:0]] = r[w[11:8]] - r[w[7:4]];
        end
        4'd5: begin
          exp_q.push_back(ev_halt(pc));
          done = 1'b1;
        end
        4'd6: begin
          exp_q.push_back(ev_settle(tgt));
          pc = tgt; lat = 2;
        end
        4'd7: begin
          exp_q.push_back(ev_brz(w[11:8], 3'd0));
          if (r[w[11:8]] == 8'd0) begin
            exp_q.push_back(ev_settle(tgt));
            pc = tgt; lat = 2;
          end
        end
        default: ;
      endcase
      gap = 2 + lat + STEP_X;
    end
    halt_pc = pc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_env();
    for (int a = 0; a < ROM_N; a++) rom[a] = 16'($urandom);
    for (int i = 0; i < 256; i++) dmem_init[i] = 8'($urandom_range(0, 3));
  endtask

  task automatic gen_random_prog();
    int len, sel, tgt;
    logic [15:0] w;
    fill_env();
    len = $urandom_range(8, 40);
    for (int a = 0; a < len - 1; a++) begin
      sel = $urandom_range(0, 9);
      w = 16'($urandom);
      tgt = $urandom_range(a + 1, len - 1);
      case (sel)
        0: w[15:12] = 4'h0;
        1: w[15:12] = 4'h1;
        2, 8: w[15:12] = 4'h2;
        3: w[15:12] = 4'h3;
        4: w[15:12] = 4'h4;
        5: begin w[15:12] = 4'h6; w[PC_W-1:0] = PC_W'(tgt); end
        6, 9: begin w[15:12] = 4'h7; w[PC_W-1:0] = PC_W'(tgt); end
        default: w[15:12] = 4'(8 + $urandom_range(0, 7));
      endcase
      rom[a] = w;
    end
    rom[len - 1] = {4'h5, 12'($urandom)};
  endtask

  task automatic run_prog(input string nm);
    int cyc, bad;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    model_run();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    while (!bus.halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check(bus.halted == 1'b1, {nm, "_halt_reached"}, 32'(bus.halted), 32'd1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (!(bus.OutState == S_HALT && bus.halted && int'(bus.PC_Out) == halt_pc)) bad++;
    end
    check(bad == 0, {nm, "_halt_hold"}, 32'(bad), 32'd0);
    check(exp_q.size() == 0, {nm, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, n, gcnt;
    fill_env();
    rst_n = 1'b0;
    rst_w_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(bus.OutState == S_INIT, "reset_state", 32'(bus.OutState), 32'd0);
    check(bus.IR_Out == 16'd0, "reset_ir", 32'(bus.IR_Out), 32'd0);
    check(int'(bus.PC_Out) == RESET_PC, "reset_pc", 32'(bus.PC_Out), 32'(RESET_PC));
    check(ctl_bits() == 32'd0, "reset_ctl", ctl_bits(), 32'd0);

    // PC wrap on a 3-bit counter running NOOPs.
    @(posedge clk);
    #2 rst_w_n = 1'b1;
    n = 0; gcnt = 0; cyc = 0;
    while (n < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (wbus.OutState == S_FETCH) begin
        check({gcnt, int'(wbus.PC_Out)} == {(n == 0) ? 1 : 3 + STEP_X, n % 8}, "wrap_fetch",
              32'({8'(gcnt), 8'(wbus.PC_Out)}), 32'({8'((n == 0) ? 1 : 3 + STEP_X), 8'(n % 8)}));
        n++;
        gcnt = 1;
      end else begin
        gcnt++;
      end
    end
    check(n == 20, "wrap_progress", 32'(n), 32'd20);

    // LOAD/LOAD/SUB/STORE/HALT program.
    fill_env();
    rom[0] = 16'h210B; rom[1] = 16'h221B; rom[2] = 16'h4125; rom[3] = 16'h1CD5; rom[4] = 16'h5000;
    run_prog("prog_sub_store");

    // Single load with multi-cycle data memory.
    fill_env();
    rom[0] = 16'h248A; rom[1] = 16'h5000;
    run_prog("prog_load");

    // JMP to 5 from address 2; bits above the PC width are ignored.
    fill_env();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h6F85;
    rom[3] = 16'h1111; rom[4] = 16'h1222; rom[5] = 16'h5000;
    run_prog("prog_jmp");

    // BRZ not taken, then taken.
    fill_env();
    dmem_init[16] = 8'd5;
    rom[0] = 16'h2310; rom[1] = 16'h7306; rom[2] = 16'h5000; rom[6] = 16'h5000;
    run_prog("prog_brz_nt");
    dmem_init[16] = 8'd0;
    run_prog("prog_brz_t");

    // Reset asserted in the middle of LOAD_A.
    fill_env();
    rom[0] = 16'h248A; rom[1] = 16'h5000;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    exp_q.push_back(ev_fetch(1, RESET_PC));
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    while (bus.OutState != S_LOAD_A && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check(bus.OutState == S_LOAD_A, "reach_load_a", 32'(bus.OutState), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(bus.OutState == S_INIT, "midload_rst_state", 32'(bus.OutState), 32'd0);
    check(ctl_bits() == 32'd0, "midload_rst_ctl", ctl_bits(), 32'd0);
    check(int'(bus.PC_Out) == RESET_PC, "midload_rst_pc", 32'(bus.PC_Out), 32'(RESET_PC));
    repeat (3) @(posedge clk);
    check(exp_q.size() == 0, "midload_drain", 32'(exp_q.size()), 32'd0);
    run_prog("prog_restart");

    for (int k = 0; k < 6; k++) begin
      gen_random_prog();
      run_prog($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/control_unit_p.md
Name: control_unit_p

Overview:
Parametrised fetch/decode/execute control unit for the ProjectB processor. Its job is to drive the register file, data memory and ALU in the datapath. Successor to the fixed single-program control unit, with these changes:
- instruction memory is external;
- PC width and data-memory read latency are parameters;
- JMP and BRZ instructions are added.

Parameters:
PC_W, 7, program counter / instruction address width (1..8)
RESET_PC, 0, PC value on reset
DMEM_LAT, 1, data-memory read latency in cycles (>=1); LOAD_A dwell length

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
imem_addr  out  PC_W  instruction memory address (= PC)
imem_data  in  16  instruction word; synchronous ROM, valid one cycle after imem_addr is sampled
alu_zero  in  1  datapath ALU-result-is-zero flag, combinational
D_addr  out  8  data memory address
D_wr  out  1  data memory write enable
RF_s  out  1  register-file write mux select (1 = data memory, 0 = ALU)
RF_W_en  out  1  register-file write enable
RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  4 each  register-file addresses
ALU_s0  out  3  ALU op: 000 pass A, 001 add, 010 sub
IR_Out  out  16  instruction register
PC_Out  out  PC_W  program counter
OutState, NextState  out  4 each  current/next FSM state code
halted  out  1  high while in HALT

Behaviour:
- Reset (low, async): PC=RESET_PC, IR=0, state=INIT; all control outputs 0, halted=0.
- Opcodes IR[15:12]:
  - NOOP 0000
  - STORE 0001: D_addr=IR[11:4], Ra=IR[3:0]
  - LOAD 0010: Rd=IR[11:8], D_addr=IR[7:0]
  - ADD 0011 / SUB 0100: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]
  - HALT 0101
  - JMP 0110: target=IR[PC_W-1:0]
  - BRZ 0111: Ra=IR[11:8], target=IR[PC_W-1:0]
  - 1000..1111: executed as NOOP.
- State codes:
  - INIT 0, FETCH 1, DECODE 2, LOAD_A 3, LOAD_B 4, STORE 5, ADD 6, SUB 7
  - NOOP 8, HALT 9, JUMP 10, BRZ 11, SETTLE 12
  - 13..15 unused; any illegal state goes to INIT next cycle.
- Output defaults: every output not listed for a state is 0.
- INIT: go to FETCH.
- FETCH: IR<=imem_data, PC<=PC+1 (wraps modulo 2^PC_W); go to DECODE.
- DECODE: no outputs; branch to the state selected by the opcode.
- LOAD_A:
  - D_addr and RF_W_addr driven, RF_s=1.
  - Dwells DMEM_LAT cycles on an internal counter that clears on entry, then goes to LOAD_B.
- LOAD_B: as LOAD_A plus RF_W_en=1; go to FETCH.
- STORE: D_addr and RF_Ra_addr driven, D_wr=1 for exactly 1 cycle; go to FETCH.
- ADD / SUB:
  - RF_Ra_addr, RF_Rb_addr and RF_W_addr driven; RF_W_en=1, RF_s=0.
  - ALU_s0=001 for ADD, 010 for SUB.
  - Go to FETCH.
- JUMP: PC<=target; go to SETTLE.
- BRZ:
  - RF_Ra_addr driven, ALU_s0=000.
  - If alu_zero=1: PC<=target, go to SETTLE; otherwise go to FETCH (PC unchanged).
- SETTLE: one idle cycle so the ROM samples the new PC; go to FETCH.
- HALT: halted=1; state held until reset, PC frozen.
- Execute-state latency from DECODE exit back to FETCH:
  - NOOP, STORE, ADD, SUB: 1 cycle.
  - LOAD: DMEM_LAT+1 cycles.
  - Taken JMP/BRZ: 2 cycles.
- JMP/BRZ to its own address is legal: an intentional spin loop.
- NextState is the combinational next-state value; OutState is the registered state.
- Reset mid-instruction: immediate return to reset values; a partial LOAD never writes and a STORE pulse is truncated.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - Adds input port step (1 bit, synchronous pulse) and state STEP_WAIT, code 13.
  - Every completed instruction goes to STEP_WAIT instead of FETCH; STEP_WAIT waits for step=1, then goes to FETCH.
  - step held high advances one instruction per pass.
- Undefined: no step port; state 13 is illegal (goes to INIT).

Decomposition:
- Package cu_pkg:
  - state_t enum with the codes above;
  - opcode_t enum;
  - ALU_PASS/ALU_ADD/ALU_SUB constants;
  - instruction field localparams.
- One sub-module pc_counter_p (params PC_W, RESET_PC):
  - async active-low reset;
  - priority: load > clear > up.

Test Plan:
- Program LOAD R1<-D[11], LOAD R2<-D[27], SUB R5=R1-R2, STORE R5->D[205], HALT:
  - each instruction enters state 1 exactly once;
  - D_wr high 1 cycle with D_addr=205;
  - OutState reaches 9 and holds for 10+ cycles.
- DMEM_LAT=3, LOAD R4<-D[138]:
  - LOAD_A for exactly 3 cycles, then a single RF_W_en pulse with RF_W_addr=4, RF_s=1, D_addr=138.
- JMP 0x05 at address 2:
  - PC_Out=5 in SETTLE;
  - next FETCH loads the word at address 5;
  - addresses 3 and 4 are never fetched.
- BRZ with alu_zero=0 falls through (PC=addr+1); with alu_zero=1 PC becomes target. RF_Ra_addr=IR[11:8] and ALU_s0=000 in state 11 for both cases.
- PC wrap: PC_W=3, a NOOP-only program runs PC 7->0 without stalling.
- Reset asserted during LOAD_A: all outputs 0 and state 0 within the same cycle; RF_W_en never pulses; execution restarts from RESET_PC.
